// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one outstanding read at a time and
// buffers returned words with their addresses in a DEPTH-entry FIFO for the ID stage.
module if_prefetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int                    INST_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    if_rst_n,
  input  logic                    redirect_en,
  input  logic [ADDR_WIDTH-1:0]   redirect_addr,
  output logic                    inst_ren,
  output logic [ADDR_WIDTH-1:0]   inst_addr,
  input  logic                    inst_ready,
  input  logic                    inst_rvalid,
  input  logic [DATA_WIDTH-1:0]   inst_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH-1:0]   out_addr_next,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    pending
);

  localparam int             PW      = $clog2(DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INST_BYTES);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  drop;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic        accept;
  logic        complete;
  logic        push;
  logic        pop;
  logic [CW:0] reserved;

  // A FIFO slot is reserved as soon as a request is issued, so the queue cannot overflow.
  assign reserved = {1'b0, count} + {{CW{1'b0}}, pending};
  assign inst_ren = if_rst_n & ~redirect_en & (~pending | inst_rvalid) & (reserved < DEPTH_C);
  assign inst_addr = pc;

  assign accept   = inst_ren & inst_ready;
  assign complete = inst_rvalid & pending;
  assign push     = if_rst_n & complete & ~drop & ~redirect_en;
  assign pop      = if_rst_n & out_valid & out_ready & ~redirect_en;

  assign out_valid     = (count != '0);
  assign out_addr      = addr_mem[rd_ptr];
  assign out_data      = data_mem[rd_ptr];
  assign out_addr_next = out_addr + STEP;

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!if_rst_n) begin
      pc       <= RESET_ADDR;
      req_addr <= RESET_ADDR;
      pending  <= 1'b0;
      drop     <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (redirect_en) begin
      pc     <= redirect_addr;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      // A stale request still in flight must have its response thrown away.
      if (pending) begin
        if (inst_rvalid) begin
          pending <= 1'b0;
          drop    <= 1'b0;
        end else begin
          drop    <= 1'b1;
        end
      end
    end else begin
      if (accept) begin
        pending  <= 1'b1;
        req_addr <= pc;
        pc       <= pc + STEP;
      end else if (complete) begin
        pending  <= 1'b0;
      end

      if (complete) drop <= 1'b0;

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= req_addr;
      data_mem[wr_ptr] <= inst_data;
    end
  end

endmodule
